// File: rtl/arith_pkg.sv
// arith_pkg: definitions shared by the serial adder and its bit slice.
//   WIDTH_DEFAULT : default operand width of serial_adder
//   state_e       : control FSM states (IDLE, BUSY, DONE)
package arith_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : arith_pkg

// File: rtl/serial_adder_full_adder.sv
// full_adder: combinational 1-bit full adder used as the serial bit slice.
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit   (a ^ b ^ cin)
//   cout  : carry out (majority of a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one bit per clock, LSB first.
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset (wins over start)
//   start : load a/b and begin an addition (accepted in IDLE or DONE only)
//   a, b  : operands, sampled on the accepting edge
//   busy  : high for the WIDTH cycles in which bits are processed
//   done  : one-cycle pulse when sum/cout hold the final result
//   sum   : a + b mod 2^WIDTH, updated only when an addition completes
//   cout  : carry out of the MSB, updated together with sum
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra counter bit so the terminal count WIDTH-1 never wraps.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q,  a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,  b_sh_d;
  logic [WIDTH-1:0]   acc_q,   acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic [WIDTH-1:0]   sum_q,   sum_d;
  logic               cout_q,  cout_d;

  logic               fa_s;
  logic               fa_c;
  logic [WIDTH-1:0]   msb_s;
  logic [WIDTH-1:0]   acc_shift_s;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Next state, datapath shifting and registered output values.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    // New sum bit enters at the MSB; built this way so WIDTH=1 needs no slice.
    msb_s              = '0;
    msb_s[WIDTH-1]     = fa_s;
    acc_shift_s        = (acc_q >> 1) | msb_s;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          acc_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = BUSY;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        acc_d   = acc_shift_s;
        carry_d = fa_c;
        if (cnt_q == LAST_CNT) begin
          // Last bit: publish the result; visible outputs never show partials.
          state_d = DONE;
          done_d  = 1'b1;
          sum_d   = acc_shift_s;
          cout_d  = fa_c;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=8).
// Expected results are queued when an operation is started and checked by a
// monitor when done pulses; directed sequences cover the multi-cycle cases.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  typedef struct {
    logic [W:0] res;
    int         acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[7];

  int n_vec    = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int done_cnt = 0;

  logic         prev_busy = 1'b0;
  logic         prev_done = 1'b0;
  logic [W-1:0] prev_sum  = '0;
  logic         prev_cout = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: done pulse width, output stability while busy, scoreboard pop.
  always @(negedge clk) begin
    if (busy === 1'b1 && prev_busy === 1'b1) begin
      check("sum_stable_busy", {24'd0, sum}, {24'd0, prev_sum});
      check("cout_stable_busy", {31'd0, cout}, {31'd0, prev_cout});
    end
    if (done === 1'b1) begin
      done_cnt++;
      check("done_one_cycle", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: done high with no pending operation (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result", {23'd0, cout, sum}, {23'd0, mon_e.res});
        check("latency", cyc - mon_e.acc_cyc, W);
      end
    end
    prev_busy = busy;
    prev_done = done;
    prev_sum  = sum;
    prev_cout = cout;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge; queue the expected result if it will be accepted.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit accept);
    exp_t e;
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    tick();
    start = 1'b0;
    if (accept) begin
      e.res     = {1'b0, ta} + {1'b0, tb_v};
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * W + 4; i++) begin
      tick();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: done never seen within %0d cycles", 2 * W + 4);
    end
  endtask

  initial begin
    bit ok;
    int d0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{a: 8'h0F, b: 8'h01, s: 8'h10, c: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1};
    vecs[5] = '{a: 8'hAA, b: 8'h55, s: 8'hFF, c: 1'b0};
    vecs[6] = '{a: 8'h7F, b: 8'h01, s: 8'h80, c: 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum",  {24'd0, sum},  32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    tick();

    // 0x0F + 0x01: busy exactly 8 cycles, then a single done.
    start_op(8'h0F, 8'h01, 1'b1);
    for (int k = 0; k < W; k++) begin
      check("busy_window", {31'd0, busy}, 32'd1);
      check("no_early_done", {31'd0, done}, 32'd0);
      tick();
    end
    check("busy_end", {31'd0, busy}, 32'd0);
    check("done_at_w", {31'd0, done}, 32'd1);
    check("sum_0f01", {24'd0, sum}, 32'h10);
    check("cout_0f01", {31'd0, cout}, 32'd0);
    tick();
    check("done_drop", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Table vectors.
    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b, 1'b1);
      wait_done(ok);
      if (ok) begin
        check("vec_sum", {24'd0, sum}, {24'd0, vecs[i].s});
        check("vec_cout", {31'd0, cout}, {31'd0, vecs[i].c});
      end
      tick();
    end

    // start during BUSY is ignored.
    d0 = done_cnt;
    start_op(8'h33, 8'h44, 1'b1);
    tick();
    tick();
    start_op(8'h55, 8'h11, 1'b0);
    wait_done(ok);
    check("ignore_sum", {24'd0, sum}, 32'h77);
    check("ignore_cout", {31'd0, cout}, 32'd0);
    repeat (12) tick();
    check("ignore_one_done", done_cnt - d0, 1);

    // Reset in the 4th BUSY cycle aborts without done.
    start_op(8'hF0, 8'h0F, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sum",  {24'd0, sum},  32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    d0 = done_cnt;
    repeat (12) tick();
    check("abort_no_done", done_cnt - d0, 0);

    // Reset wins over start in the same cycle.
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h01;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_prio_busy", {31'd0, busy}, 32'd0);
    tick();
    check("rst_prio_idle", {31'd0, busy}, 32'd0);

    // Back-to-back: start held in DONE begins a new op without IDLE.
    start_op(8'h12, 8'h34, 1'b1);
    wait_done(ok);
    start_op(8'h80, 8'h80, 1'b1);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_done_low", {31'd0, done}, 32'd0);
    wait_done(ok);
    check("b2b_sum", {24'd0, sum}, 32'h00);
    check("b2b_cout", {31'd0, cout}, 32'd1);
    tick();

    // Random operands, sometimes back-to-back.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      start_op(ra, rb, 1'b1);
      wait_done(ok);
      if ($urandom_range(0, 1) == 1) tick();
    end

    repeat (4) tick();
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_serial_adder
